stream_packer: RTL and testbench

Packs a stream of D_WIDTH-bit words from the tail of the two-shift-register/custom-logic pipeline into PACK-word-wide beats for the consumer side. It is the stage directly downstream of the pipeline's down_data/down_valid/down_ready port. Packets can be closed early with up_last, which produces a short beat with a word count. One output holding register gives full throughput of one input word per cycle.

---
 rtl/stream_pkg.sv | 12 +
 rtl/pack_out_reg.sv | 38 +++
 rtl/stream_packer.sv | 84 ++++++++
 tb/tb_stream_packer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared constants and helpers for the stream pipeline stages.
package stream_pkg;

   localparam int D_WIDTH_DEF = 6;
   localparam int PACK_DEF    = 4;

   // Width needed to hold a word count of 0..p.
   function automatic int cnt_w(input int p);
      return $clog2(p + 1);
   endfunction

endpackage

// File: rtl/pack_out_reg.sv
// Single-entry valid/ready holding register for a data word plus a count.
// load must only be asserted when load_ok is high; the contents stay put
// while out_valid is high and the consumer is stalling.
module pack_out_reg #(
   parameter int DATA_W = 24,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CNT_W-1:0]  in_count,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_valid,
   output logic              load_ok
);

   // The slot is free when it is empty or being emptied this cycle.
   assign load_ok = !out_valid || out_ready;

   // Reload on a new entry, otherwise drop valid once the consumer takes it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_data  <= '0;
         out_count <= '0;
         out_valid <= 1'b0;
      end else if (load) begin
         out_data  <= in_data;
         out_count <= in_count;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/stream_packer.sv
// Packs D_WIDTH-bit words into PACK-word beats; up_last closes a packet
// early with a short beat and a word count.
module stream_packer
   import stream_pkg::*;
#(
   parameter int D_WIDTH = D_WIDTH_DEF,
   parameter int PACK    = PACK_DEF,
   localparam int CW     = cnt_w(PACK)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [D_WIDTH-1:0]      up_data,
   input  logic                    up_valid,
   input  logic                    up_last,
   output logic                    up_ready,
   output logic [PACK*D_WIDTH-1:0] down_data,
   output logic [CW-1:0]           down_count,
   output logic                    down_valid,
   input  logic                    down_ready
);

   localparam int IW = $clog2(PACK);
   localparam int AW = PACK * D_WIDTH;

   logic [AW-1:0] acc;
   logic [AW-1:0] acc_wr;
   logic [AW-1:0] beat;
   logic [IW-1:0] idx;
   logic [CW-1:0] beat_count;
   logic          accept;
   logic          complete;
   logic          slot_free;

   assign up_ready   = slot_free;
   assign accept     = up_valid && slot_free;
   assign complete   = accept && (up_last || (idx == IW'(PACK - 1)));
   assign beat_count = CW'(idx) + CW'(1);

   // Build the outgoing beat (lanes below idx from acc, lane idx from the
   // input, lanes above forced to zero) and the accumulator write value.
   always_comb begin
      beat   = '0;
      acc_wr = acc;
      for (int k = 0; k < PACK; k++) begin
         if (IW'(k) == idx) begin
            beat[k*D_WIDTH +: D_WIDTH]   = up_data;
            acc_wr[k*D_WIDTH +: D_WIDTH] = up_data;
         end else if (IW'(k) < idx) begin
            beat[k*D_WIDTH +: D_WIDTH]   = acc[k*D_WIDTH +: D_WIDTH];
         end
      end
   end

   // Accumulate words; a completion hands the beat off and restarts at lane 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
         idx <= '0;
      end else if (complete) begin
         acc <= '0;
         idx <= '0;
      end else if (accept) begin
         acc <= acc_wr;
         idx <= idx + IW'(1);
      end
   end

   pack_out_reg #(
      .DATA_W (AW),
      .CNT_W  (CW)
   ) u_out_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (complete),
      .in_data   (beat),
      .in_count  (beat_count),
      .out_ready (down_ready),
      .out_data  (down_data),
      .out_count (down_count),
      .out_valid (down_valid),
      .load_ok   (slot_free)
   );

endmodule

// File: tb/tb_stream_packer.sv
// Directed bench for stream_packer with D_WIDTH = 6, PACK = 4.
module tb_stream_packer;

   localparam int DW = 6;
   localparam int PK = 4;
   localparam int CW = 3;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [DW-1:0]  up_data = '0;
   logic           up_valid = 1'b0;
   logic           up_last = 1'b0;
   logic           up_ready;
   logic [PK*DW-1:0] down_data;
   logic [CW-1:0]  down_count;
   logic           down_valid;
   logic           down_ready = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   stream_packer #(.D_WIDTH(DW), .PACK(PK)) dut (
      .clk        (clk),
      .rst        (rst),
      .up_data    (up_data),
      .up_valid   (up_valid),
      .up_last    (up_last),
      .up_ready   (up_ready),
      .down_data  (down_data),
      .down_count (down_count),
      .down_valid (down_valid),
      .down_ready (down_ready)
   );

   typedef struct {
      logic          v;
      logic          l;
      logic [DW-1:0] d;
      logic          dr;
      logic          exp_ur;
      logic          exp_dv;
      logic [23:0]   exp_dd;
      logic [CW-1:0] exp_dc;
   } vec_t;

   vec_t tv[$];

   function automatic logic [23:0] pk(input logic [5:0] a, input logic [5:0] b,
                                      input logic [5:0] c, input logic [5:0] d);
      return {d, c, b, a};
   endfunction

   function automatic vec_t mk(input logic v, input logic l, input logic [5:0] d,
                               input logic dr, input logic ur, input logic dv,
                               input logic [23:0] dd, input logic [2:0] dc);
      vec_t r;
      r.v = v; r.l = l; r.d = d; r.dr = dr;
      r.exp_ur = ur; r.exp_dv = dv; r.exp_dd = dd; r.exp_dc = dc;
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Drive one cycle: check up_ready before the edge, outputs after it.
   task automatic apply(input vec_t t, input int n);
      string tag;
      tag = $sformatf("v%0d", n);
      up_valid   = t.v;
      up_last    = t.l;
      up_data    = t.d;
      down_ready = t.dr;
      #1;
      check({tag, " up_ready"}, 32'(up_ready), 32'(t.exp_ur));
      @(posedge clk);
      #1;
      check({tag, " down_valid"}, 32'(down_valid), 32'(t.exp_dv));
      if (t.exp_dv) begin
         check({tag, " down_data"}, 32'(down_data), 32'(t.exp_dd));
         check({tag, " down_count"}, 32'(down_count), 32'(t.exp_dc));
      end
   endtask

   initial begin
      logic [23:0] beat1;
      int n;

      // Full beat from the documented example.
      tv.push_back(mk(1, 0, 6'h01, 1, 1, 0, 24'h0, 0));
      tv.push_back(mk(1, 0, 6'h02, 1, 1, 0, 24'h0, 0));
      tv.push_back(mk(1, 0, 6'h03, 1, 1, 0, 24'h0, 0));
      tv.push_back(mk(1, 0, 6'h04, 1, 1, 1, 24'h103081, 4));
      // Short packet, next packet starts at lane 0.
      tv.push_back(mk(1, 0, 6'h3F, 1, 1, 0, 24'h0, 0));
      tv.push_back(mk(1, 1, 6'h2A, 1, 1, 1, 24'h000ABF, 2));
      // Back-to-back words 0..7, no bubble.
      for (int i = 0; i < 8; i++) begin
         logic [5:0] w;
         w = 6'(i);
         if (i == 3)
            tv.push_back(mk(1, 0, w, 1, 1, 1, pk(6'h0, 6'h1, 6'h2, 6'h3), 4));
         else if (i == 7)
            tv.push_back(mk(1, 0, w, 1, 1, 1, pk(6'h4, 6'h5, 6'h6, 6'h7), 4));
         else
            tv.push_back(mk(1, 0, w, 1, 1, 0, 24'h0, 0));
      end
      // Data/last ignored without valid.
      tv.push_back(mk(0, 1, 6'h3F, 1, 1, 0, 24'h0, 0));
      // up_last on the first word.
      tv.push_back(mk(1, 1, 6'h15, 1, 1, 1, pk(6'h15, 6'h0, 6'h0, 6'h0), 1));
      // up_last on the final lane: one normal beat, no extra empty beat.
      tv.push_back(mk(1, 0, 6'h11, 1, 1, 0, 24'h0, 0));
      tv.push_back(mk(1, 0, 6'h12, 1, 1, 0, 24'h0, 0));
      tv.push_back(mk(1, 0, 6'h13, 1, 1, 0, 24'h0, 0));
      tv.push_back(mk(1, 1, 6'h14, 1, 1, 1, pk(6'h11, 6'h12, 6'h13, 6'h14), 4));
      tv.push_back(mk(0, 0, 6'h00, 1, 1, 0, 24'h0, 0));
      tv.push_back(mk(0, 0, 6'h00, 1, 1, 0, 24'h0, 0));

      // Reset values.
      repeat (2) @(posedge clk);
      #2;
      check("rst down_valid", 32'(down_valid), 32'd0);
      check("rst down_data", 32'(down_data), 32'd0);
      check("rst down_count", 32'(down_count), 32'd0);
      check("rst up_ready", 32'(up_ready), 32'd1);
      @(posedge clk);
      #1 rst = 1'b1;

      n = 0;
      foreach (tv[i]) begin
         apply(tv[i], n);
         n++;
      end

      // Backpressure: build a beat with down_ready low, then stall on it.
      beat1 = pk(6'h21, 6'h22, 6'h23, 6'h24);
      apply(mk(1, 0, 6'h21, 0, 1, 0, 24'h0, 0), 100);
      apply(mk(1, 0, 6'h22, 0, 1, 0, 24'h0, 0), 101);
      apply(mk(1, 0, 6'h23, 0, 1, 0, 24'h0, 0), 102);
      apply(mk(1, 0, 6'h24, 0, 1, 1, beat1, 4), 103);
      for (int i = 0; i < 4; i++)
         apply(mk(1, 0, 6'h31, 0, 0, 1, beat1, 4), 110 + i);
      // One cycle of down_ready drains beat1 and accepts 0x31 together.
      apply(mk(1, 0, 6'h31, 1, 1, 0, 24'h0, 0), 120);
      apply(mk(1, 1, 6'h32, 1, 1, 1, pk(6'h31, 6'h32, 6'h0, 6'h0), 2), 121);
      apply(mk(1, 0, 6'h33, 0, 0, 1, pk(6'h31, 6'h32, 6'h0, 6'h0), 2), 122);
      // Completion in the same cycle the held beat is taken.
      apply(mk(1, 1, 6'h35, 1, 1, 1, pk(6'h35, 6'h0, 6'h0, 6'h0), 1), 123);
      apply(mk(0, 0, 6'h00, 1, 1, 0, 24'h0, 0), 124);

      // Reset mid-packet after two accepted words.
      apply(mk(1, 0, 6'h0A, 1, 1, 0, 24'h0, 0), 130);
      apply(mk(1, 0, 6'h0B, 1, 1, 0, 24'h0, 0), 131);
      up_valid = 1'b0;
      up_last  = 1'b0;
      rst = 1'b0;
      #1;
      check("mid rst down_valid", 32'(down_valid), 32'd0);
      check("mid rst down_data", 32'(down_data), 32'd0);
      check("mid rst down_count", 32'(down_count), 32'd0);
      check("mid rst up_ready", 32'(up_ready), 32'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      apply(mk(1, 0, 6'h3C, 1, 1, 0, 24'h0, 0), 140);
      apply(mk(1, 0, 6'h3D, 1, 1, 0, 24'h0, 0), 141);
      apply(mk(1, 0, 6'h3E, 1, 1, 0, 24'h0, 0), 142);
      apply(mk(1, 0, 6'h3F, 1, 1, 1, pk(6'h3C, 6'h3D, 6'h3E, 6'h3F), 4), 143);
      apply(mk(1, 0, 6'h07, 1, 1, 0, 24'h0, 0), 144);
      apply(mk(1, 1, 6'h08, 1, 1, 1, pk(6'h07, 6'h08, 6'h0, 6'h0), 2), 145);
      apply(mk(0, 0, 6'h00, 1, 1, 0, 24'h0, 0), 146);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
